// File: rtl/perceptron_sample_loader.sv
// perceptron_sample_loader: captures a byte-serial load frame (marker, weights,
// samples) into an internal buffer, then replays the buffer to the trainer as a
// valid/ready sample stream for a programmable number of epochs.
module perceptron_sample_loader #(
    parameter int N_SAMPLES = 3,
    parameter int INP_DIM   = 2,
    parameter int DATA_W    = 8
) (
    input  logic                                                    clk,
    input  logic                                                    rst_n,
    input  logic                                                    in_valid,
    input  logic [DATA_W-1:0]                                       in_data,
    output logic                                                    in_ready,
    input  logic                                                    start,
    input  logic [3:0]                                              epochs,
    output logic                                                    smp_valid,
    input  logic                                                    smp_ready,
    output logic [INP_DIM*DATA_W-1:0]                               smp_x,
    output logic [DATA_W-1:0]                                       smp_y,
    output logic [((N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1)-1:0]    smp_idx,
    output logic                                                    smp_last,
    output logic [INP_DIM*DATA_W-1:0]                               w_init,
    output logic                                                    w_init_valid,
    output logic                                                    done
);

    localparam int IDX_W     = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1;
    localparam int SMP_BYTES = INP_DIM + 1;
    localparam int BUF_BYTES = N_SAMPLES * SMP_BYTES;
    localparam int CNT_MAX   = (BUF_BYTES > INP_DIM) ? BUF_BYTES : INP_DIM;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);

    localparam logic [DATA_W-1:0] FRAME_SOF = DATA_W'(8'hA5);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LOAD_W = 3'd1;
    localparam logic [2:0] LOAD_S = 3'd2;
    localparam logic [2:0] LOADED = 3'd3;
    localparam logic [2:0] STREAM = 3'd4;
    localparam logic [2:0] DONE   = 3'd5;

    logic [2:0]                state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [DATA_W-1:0]         w_q   [INP_DIM];
    logic [DATA_W-1:0]         w_d   [INP_DIM];
    logic [DATA_W-1:0]         buf_q [BUF_BYTES];
    logic [DATA_W-1:0]         buf_d [BUF_BYTES];
    logic                      w_init_valid_q, w_init_valid_d;
    logic [3:0]                epochs_q, epochs_d;
    logic [3:0]                ep_cnt_q, ep_cnt_d;
    logic [IDX_W-1:0]          smp_idx_q, smp_idx_d;
    logic                      smp_valid_q, smp_valid_d;
    logic [INP_DIM*DATA_W-1:0] smp_x_q, smp_x_d;
    logic [DATA_W-1:0]         smp_y_q, smp_y_d;
    logic                      smp_last_q, smp_last_d;
    logic                      done_q, done_d;

    logic                      byte_xfer;
    logic                      beat_xfer;
    logic                      load_sample;
    logic [IDX_W-1:0]          next_idx;

    assign in_ready = (state_q == IDLE) || (state_q == LOAD_W) || (state_q == LOAD_S);

    // Next-state logic for the load path, the stream sequencer and the beat registers
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        w_d            = w_q;
        buf_d          = buf_q;
        w_init_valid_d = w_init_valid_q;
        epochs_d       = epochs_q;
        ep_cnt_d       = ep_cnt_q;
        smp_idx_d      = smp_idx_q;
        smp_valid_d    = smp_valid_q;
        smp_x_d        = smp_x_q;
        smp_y_d        = smp_y_q;
        smp_last_d     = smp_last_q;
        done_d         = 1'b0;
        load_sample    = 1'b0;
        next_idx       = smp_idx_q;
        byte_xfer      = in_valid && in_ready;
        beat_xfer      = smp_valid_q && smp_ready;

        case (state_q)
            IDLE: begin
                if (byte_xfer && (in_data == FRAME_SOF)) begin
                    state_d = LOAD_W;
                    cnt_d   = '0;
                end
            end
            LOAD_W: begin
                if (byte_xfer) begin
                    for (int unsigned i = 0; i < INP_DIM; i++) begin
                        if (cnt_q == CNT_W'(i)) w_d[i] = in_data;
                    end
                    if (cnt_q == CNT_W'(INP_DIM - 1)) begin
                        state_d = LOAD_S;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            LOAD_S: begin
                if (byte_xfer) begin
                    for (int unsigned p = 0; p < BUF_BYTES; p++) begin
                        if (cnt_q == CNT_W'(p)) buf_d[p] = in_data;
                    end
                    if (cnt_q == CNT_W'(BUF_BYTES - 1)) begin
                        state_d        = LOADED;
                        cnt_d          = '0;
                        w_init_valid_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            LOADED: begin
                if (start) begin
                    if (epochs != '0) begin
                        epochs_d    = epochs;
                        ep_cnt_d    = '0;
                        next_idx    = '0;
                        load_sample = 1'b1;
                        smp_valid_d = 1'b1;
                        state_d     = STREAM;
                    end else begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            STREAM: begin
                if (beat_xfer) begin
                    if (smp_idx_q == IDX_W'(N_SAMPLES - 1)) begin
                        if (ep_cnt_q == epochs_q - 4'd1) begin
                            smp_valid_d = 1'b0;
                            state_d     = DONE;
                            done_d      = 1'b1;
                        end else begin
                            ep_cnt_d    = ep_cnt_q + 4'd1;
                            next_idx    = '0;
                            load_sample = 1'b1;
                        end
                    end else begin
                        next_idx    = smp_idx_q + 1'b1;
                        load_sample = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = LOADED;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Beat registers are refilled only when a new sample is presented, so
        // they hold still through any stall.
        if (load_sample) begin
            smp_idx_d  = next_idx;
            smp_last_d = (next_idx == IDX_W'(N_SAMPLES - 1));
            for (int unsigned s = 0; s < N_SAMPLES; s++) begin
                if (IDX_W'(s) == next_idx) begin
                    for (int unsigned k = 0; k < INP_DIM; k++) begin
                        smp_x_d[k*DATA_W +: DATA_W] = buf_q[s*SMP_BYTES + k];
                    end
                    smp_y_d = buf_q[s*SMP_BYTES + INP_DIM];
                end
            end
        end
    end

    // State and datapath registers with asynchronous active-low clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            w_q            <= '{default: '0};
            buf_q          <= '{default: '0};
            w_init_valid_q <= 1'b0;
            epochs_q       <= '0;
            ep_cnt_q       <= '0;
            smp_idx_q      <= '0;
            smp_valid_q    <= 1'b0;
            smp_x_q        <= '0;
            smp_y_q        <= '0;
            smp_last_q     <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            w_q            <= w_d;
            buf_q          <= buf_d;
            w_init_valid_q <= w_init_valid_d;
            epochs_q       <= epochs_d;
            ep_cnt_q       <= ep_cnt_d;
            smp_idx_q      <= smp_idx_d;
            smp_valid_q    <= smp_valid_d;
            smp_x_q        <= smp_x_d;
            smp_y_q        <= smp_y_d;
            smp_last_q     <= smp_last_d;
            done_q         <= done_d;
        end
    end

    // Pack the stored weights, weight 0 in the LSBs
    always_comb begin
        w_init = '0;
        for (int unsigned i = 0; i < INP_DIM; i++) begin
            w_init[i*DATA_W +: DATA_W] = w_q[i];
        end
    end

    assign smp_valid    = smp_valid_q;
    assign smp_x        = smp_x_q;
    assign smp_y        = smp_y_q;
    assign smp_idx      = smp_idx_q;
    assign smp_last     = smp_last_q;
    assign w_init_valid = w_init_valid_q;
    assign done         = done_q;

endmodule

// File: tb/tb_perceptron_sample_loader.sv
// Testbench for perceptron_sample_loader: frame loading, epoch streaming with a
// scoreboard of expected beats, stalls, zero-epoch start and reset abort.
module tb_perceptron_sample_loader;

    localparam int N = 3;
    localparam int D = 2;
    localparam int W = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [W-1:0]  in_data = '0;
    logic          in_ready;
    logic          start = 1'b0;
    logic [3:0]    epochs = '0;
    logic          smp_valid;
    logic          smp_ready = 1'b0;
    logic [D*W-1:0] smp_x;
    logic [W-1:0]  smp_y;
    logic [1:0]    smp_idx;
    logic          smp_last;
    logic [D*W-1:0] w_init;
    logic          w_init_valid;
    logic          done;

    int vec_cnt = 0;
    int err_cnt = 0;

    typedef struct packed {
        logic [D*W-1:0] x;
        logic [W-1:0]   y;
        logic [1:0]     idx;
        logic           last;
    } beat_t;

    beat_t exp_q[$];

    logic [7:0]     frame [12] = '{8'hA5, 8'h04, 8'h09,
                                   8'h02, 8'h03, 8'h00,
                                   8'h04, 8'h05, 8'h01,
                                   8'h01, 8'h02, 8'h01};
    logic [D*W-1:0] mdl_w;
    logic [D*W-1:0] mdl_x [N];
    logic [W-1:0]   mdl_y [N];

    perceptron_sample_loader #(
        .N_SAMPLES (N),
        .INP_DIM   (D),
        .DATA_W    (W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .start        (start),
        .epochs       (epochs),
        .smp_valid    (smp_valid),
        .smp_ready    (smp_ready),
        .smp_x        (smp_x),
        .smp_y        (smp_y),
        .smp_idx      (smp_idx),
        .smp_last     (smp_last),
        .w_init       (w_init),
        .w_init_valid (w_init_valid),
        .done         (done)
    );

    always #5 clk = ~clk;

    // Reference contents derived from the frame layout: marker, weights, then samples x0,x1,y
    task automatic build_model();
        mdl_w = {frame[2], frame[1]};
        for (int s = 0; s < N; s++) begin
            mdl_x[s] = {frame[3 + 3*s + 1], frame[3 + 3*s]};
            mdl_y[s] = frame[3 + 3*s + 2];
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0; start = 1'b0; smp_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input string name);
        @(negedge clk);
        vec_cnt++;
        if (in_ready !== 1'b1) begin
            err_cnt++;
            $display("FAIL %s_in_ready got=%b exp=1", name, in_ready);
        end
        in_valid = 1'b1;
        in_data  = b;
    endtask

    task automatic send_frame(input string name);
        for (int i = 0; i < 12; i++) begin
            send_byte(frame[i], name);
            if (i == 11) begin
                vec_cnt++;
                if (w_init_valid !== 1'b0) begin
                    err_cnt++;
                    $display("FAIL %s_wv_early got=%b exp=0", name, w_init_valid);
                end
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        vec_cnt++;
        if (w_init_valid !== 1'b1) begin
            err_cnt++;
            $display("FAIL %s_wv got=%b exp=1", name, w_init_valid);
        end
        vec_cnt++;
        if (in_ready !== 1'b0) begin
            err_cnt++;
            $display("FAIL %s_loaded_in_ready got=%b exp=0", name, in_ready);
        end
        vec_cnt++;
        if (w_init !== mdl_w) begin
            err_cnt++;
            $display("FAIL %s_w_init got=%h exp=%h", name, w_init, mdl_w);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        vec_cnt++;
        if (in_ready !== 1'b1) begin
            err_cnt++;
            $display("FAIL reset_in_ready got=%b exp=1", in_ready);
        end
        vec_cnt++;
        if ({smp_valid, smp_x, smp_y, smp_idx, smp_last, w_init, w_init_valid, done} !== '0) begin
            err_cnt++;
            $display("FAIL reset_outputs got=%h exp=0",
                     {smp_valid, smp_x, smp_y, smp_idx, smp_last, w_init, w_init_valid, done});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_load();
        do_reset();
        send_frame("load");
        // A marker offered while loaded must be refused
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'hA5;
        vec_cnt++;
        if (in_ready !== 1'b0) begin
            err_cnt++;
            $display("FAIL load_reload_refused got=%b exp=0", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        vec_cnt++;
        if (in_ready !== 1'b0 || w_init_valid !== 1'b1) begin
            err_cnt++;
            $display("FAIL load_still_loaded got=%b%b exp=01", in_ready, w_init_valid);
        end
    endtask

    task automatic test_preamble();
        do_reset();
        send_byte(8'h3C, "pre");
        send_byte(8'h11, "pre");
        send_frame("pre");
    endtask

    // Issue a start and track the stream against the scoreboard
    task automatic run_stream(input logic [3:0] ep, input bit stall, input int n_exp, input string name);
        beat_t got, exp_b, held;
        int    k, xfers, dones, last_k, done_k;
        bit    held_v;
        for (int e = 0; e < int'(ep); e++) begin
            for (int s = 0; s < N; s++) begin
                exp_q.push_back('{x: mdl_x[s], y: mdl_y[s], idx: 2'(s), last: (s == N - 1)});
            end
        end
        @(negedge clk);
        vec_cnt++;
        if (smp_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL %s_pre_valid got=%b exp=0", name, smp_valid);
        end
        start     = 1'b1;
        epochs    = ep;
        smp_ready = stall ? 1'b0 : 1'b1;
        xfers = 0; dones = 0; last_k = 0; done_k = -1; held_v = 1'b0; held = '0;
        for (k = 1; k <= 60; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (!stall && ep >= 4'd2 && k == 3) begin
                start  = 1'b1;
                epochs = 4'd5;
            end
            smp_ready = stall ? (k % 2 == 0) : 1'b1;
            got = '{x: smp_x, y: smp_y, idx: smp_idx, last: smp_last};
            if (k == 1 && n_exp > 0) begin
                vec_cnt++;
                if (in_ready !== 1'b0 || smp_valid !== 1'b1) begin
                    err_cnt++;
                    $display("FAIL %s_first_beat got=rdy%b val%b exp=rdy0 val1", name, in_ready, smp_valid);
                end
            end
            if (held_v) begin
                vec_cnt++;
                if (got !== held || smp_valid !== 1'b1) begin
                    err_cnt++;
                    $display("FAIL %s_stall_hold got=%h exp=%h", name, got, held);
                end
            end
            held_v = smp_valid && !smp_ready;
            held   = got;
            if (done === 1'b1) begin
                dones++;
                done_k = k;
            end
            if (smp_valid && smp_ready) begin
                xfers++;
                vec_cnt++;
                if (exp_q.size() == 0) begin
                    err_cnt++;
                    $display("FAIL %s_extra_beat got=%h exp=none", name, got);
                end else begin
                    exp_b = exp_q.pop_front();
                    if (got !== exp_b) begin
                        err_cnt++;
                        $display("FAIL %s_beat%0d got=%h exp=%h", name, xfers, got, exp_b);
                    end
                end
                if (!stall) begin
                    vec_cnt++;
                    if (k !== xfers) begin
                        err_cnt++;
                        $display("FAIL %s_beat_cycle got=%0d exp=%0d", name, k, xfers);
                    end
                end
                last_k = k;
            end
            if (dones > 0 && k > done_k + 2) break;
        end
        start     = 1'b0;
        smp_ready = 1'b0;
        vec_cnt++;
        if (dones !== 1) begin
            err_cnt++;
            $display("FAIL %s_done_count got=%0d exp=1", name, dones);
        end
        vec_cnt++;
        if (done_k !== ((n_exp == 0) ? 1 : last_k + 1)) begin
            err_cnt++;
            $display("FAIL %s_done_cycle got=%0d exp=%0d", name, done_k, (n_exp == 0) ? 1 : last_k + 1);
        end
        vec_cnt++;
        if (xfers !== n_exp) begin
            err_cnt++;
            $display("FAIL %s_xfer_count got=%0d exp=%0d", name, xfers, n_exp);
        end
        vec_cnt++;
        if (exp_q.size() !== 0) begin
            err_cnt++;
            $display("FAIL %s_sb_left got=%0d exp=0", name, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_stream();
        run_stream(4'd2, 1'b0, 6, "stream2");
    endtask

    task automatic test_stall();
        run_stream(4'd1, 1'b1, 3, "stall");
    endtask

    task automatic test_zero_epochs();
        run_stream(4'd0, 1'b0, 0, "zero");
        // Back in LOADED: the retained buffer streams again
        run_stream(4'd1, 1'b0, 3, "again");
    endtask

    task automatic test_reset_abort();
        bit activity;
        @(negedge clk);
        start = 1'b1; epochs = 4'd2; smp_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        vec_cnt++;
        if (smp_idx !== 2'd1 || smp_valid !== 1'b1) begin
            err_cnt++;
            $display("FAIL abort_pre_idx got=%0d exp=1", smp_idx);
        end
        rst_n = 1'b0;
        #1;
        vec_cnt++;
        if (in_ready !== 1'b1 ||
            {smp_valid, smp_x, smp_y, smp_idx, smp_last, w_init, w_init_valid, done} !== '0) begin
            err_cnt++;
            $display("FAIL abort_stream_outputs got=%b_%h exp=1_0", in_ready,
                     {smp_valid, smp_x, smp_y, smp_idx, smp_last, w_init, w_init_valid, done});
        end
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b1; epochs = 4'd1; smp_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        activity = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (smp_valid !== 1'b0 || done !== 1'b0) activity = 1'b1;
        end
        smp_ready = 1'b0;
        vec_cnt++;
        if (activity !== 1'b0) begin
            err_cnt++;
            $display("FAIL abort_no_beats got=%b exp=0", activity);
        end
        // Abort part-way through a frame, then reload cleanly
        send_byte(8'hA5, "midload");
        send_byte(8'h04, "midload");
        send_byte(8'h09, "midload");
        send_byte(8'h02, "midload");
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        vec_cnt++;
        if (in_ready !== 1'b1 || w_init !== '0 || w_init_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL abort_load_outputs got=%b_%h_%b exp=1_0000_0", in_ready, w_init, w_init_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        send_frame("reload");
        run_stream(4'd1, 1'b0, 3, "reload");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        build_model();
        test_reset();
        test_load();
        test_preamble();
        test_stream();
        test_stall();
        test_zero_epochs();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/perceptron_sample_loader.md
Name: perceptron_sample_loader

Overview:
Upstream feeder for the perceptron training core. It accepts a byte-serial load frame containing the initial weights and the training set (features plus label per sample) and stores it in an internal sample buffer. On a start pulse it replays the buffer to the trainer as a valid/ready sample stream for a programmable number of epochs. It replaces the hard-coded initial values the trainer currently carries.

Parameters:
N_SAMPLES, 3, number of training samples held in the buffer
INP_DIM, 2, features per sample; also the number of weights
DATA_W, 8, width of each feature, label and weight byte

Ports:
clk  in  1  system clock
rst_n  in  1  reset; asynchronous assert, active-low
in_valid  in  1  load byte valid
in_data  in  DATA_W  load byte
in_ready  out  1  loader accepts a byte this cycle
start  in  1  single-cycle pulse; begin streaming
epochs  in  4  epoch count, sampled when start is accepted
smp_valid  out  1  sample beat valid
smp_ready  in  1  trainer accepts the beat
smp_x  out  INP_DIM*DATA_W  packed features; feature 0 in the LSBs
smp_y  out  DATA_W  label (signed)
smp_idx  out  max(1,$clog2(N_SAMPLES))  index of the sample in the current beat
smp_last  out  1  final sample of the current epoch
w_init  out  INP_DIM*DATA_W  packed initial weights (signed)
w_init_valid  out  1  a complete frame has been loaded
done  out  1  one-cycle pulse after the final beat of the final epoch

Behaviour:
- Reset is asynchronous and active-low.
  - Reset applies: state=IDLE, buffer and weights cleared to 0, all counters 0.
  - Every output is 0, except in_ready=1.
- A load byte transfers when in_valid && in_ready.
- A sample beat transfers when smp_valid && smp_ready.
- States and transitions:
  - IDLE: in_ready=1. A transferred byte equal to 8'hA5 moves to LOAD_W. Any other byte is consumed and dropped; state stays IDLE.
  - LOAD_W: in_ready=1. Takes INP_DIM bytes as w_init[0..INP_DIM-1], then moves to LOAD_S.
  - LOAD_S: in_ready=1. Takes N_SAMPLES*(INP_DIM+1) bytes in sample order, each sample as x0..x(INP_DIM-1) then y. After the last byte it moves to LOADED, and w_init_valid rises in the cycle that follows.
  - LOADED: in_ready=0.
    - start with epochs!=0: latch epochs, clear the sample and epoch counters, go to STREAM. smp_valid rises on the next cycle (one cycle of start-to-valid latency).
    - start with epochs==0: go to DONE directly; no beats are issued.
    - A byte of 8'hA5 arriving in LOADED is not accepted, because in_ready=0. Reloading requires reset.
  - STREAM: in_ready=0.
    - smp_valid stays high until the last beat. smp_x, smp_y, smp_idx and smp_last are driven from registers and hold stable while smp_valid && !smp_ready.
    - After each transfer the next beat presents on the next cycle with no bubble.
    - smp_idx wraps from N_SAMPLES-1 to 0 at each epoch boundary.
    - smp_last=1 exactly when smp_idx==N_SAMPLES-1.
    - When the final beat (last sample of epoch epochs-1) transfers, smp_valid drops on the next cycle and the state moves to DONE.
  - DONE: done=1 for exactly one cycle, then back to LOADED. The buffer is retained, so start may be issued again.
- start outside LOADED is ignored, including during STREAM. The epochs input is only sampled on an accepted start.
- w_init_valid stays high from the first LOADED entry until reset.
- w_init is stable in all states except LOAD_W.
- Data is stored unmodified. Labels and weights are interpreted as signed by the consumer; the loader performs no arithmetic.
- A reset asserted mid-load or mid-stream aborts immediately to the reset state. A partial frame is discarded.

Test Plan:
1. Reset, then send A5,04,09, 02,03,00, 04,05,01, 01,02,01 with in_valid held high.
   Required: w_init={09,04}, w_init_valid=1 one cycle after the last byte, in_ready=0 in LOADED.
2. Send 3C,11 before the A5 frame.
   Required: both bytes consumed and ignored; the frame then loads as in scenario 1.
3. Loaded buffer, start with epochs=2, smp_ready held at 1.
   - Required: 6 beats on consecutive cycles, smp_idx 0,1,2,0,1,2.
   - Required: smp_last on beats 3 and 6, beat 2 carries smp_x={05,04} and smp_y=01.
   - Required: done pulses exactly once, one cycle after beat 6.
4. Start with epochs=1, smp_ready toggled 0/1 every other cycle.
   Required: each beat holds stable while stalled, no beat is duplicated or skipped, 3 transfers total.
5. Start with epochs=0.
   Required: no smp_valid; done pulses on the cycle after start; state returns to LOADED.
6. Assert rst_n=0 during beat 2 of streaming, or midway through a load.
   Required: all outputs zero immediately and in_ready=1. A start before reload produces no beats.
